// File: rtl/mac_psum_accumulator.sv
// Dual-lane partial-sum accumulator: sums cfg_acc_len signed MAC beats per lane and queues results in a 2-entry FIFO.
// Build option: define ACC_SATURATE_EN to clamp lane additions instead of wrapping.
module mac_psum_accumulator #(
  parameter int MAC_DW = 21,
  parameter int ACC_DW = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cfg_acc_len,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [2*MAC_DW-1:0]   in_dat,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [2*ACC_DW-1:0]   out_dat,
  output logic                  busy
);

  // Handshake: a transfer happens on a rising edge where vld && rdy; vld/dat hold until taken.
  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t              state;
  logic [8:0]          cnt;
  logic [8:0]          len_q;
  logic [ACC_DW-1:0]   acc0;
  logic [ACC_DW-1:0]   acc1;

  logic [2*ACC_DW-1:0] mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;

  logic                accept;
  logic                push;
  logic                pop;
  logic [2*ACC_DW-1:0] push_dat;
  logic [8:0]          len_cfg;
  logic [8:0]          cnt_nxt;
  logic [ACC_DW-1:0]   ext0;
  logic [ACC_DW-1:0]   ext1;
  logic [ACC_DW-1:0]   sum0;
  logic [ACC_DW-1:0]   sum1;

  function automatic logic [ACC_DW-1:0] lane_add(input logic [ACC_DW-1:0] a,
                                                 input logic [ACC_DW-1:0] b);
`ifdef ACC_SATURATE_EN
    logic [ACC_DW:0] s;
    s = {a[ACC_DW-1], a} + {b[ACC_DW-1], b};
    if (s[ACC_DW] != s[ACC_DW-1])
      lane_add = s[ACC_DW] ? {1'b1, {(ACC_DW-1){1'b0}}} : {1'b0, {(ACC_DW-1){1'b1}}};
    else
      lane_add = s[ACC_DW-1:0];
`else
    lane_add = a + b;
`endif
  endfunction

  assign ext0    = ACC_DW'($signed(in_dat[MAC_DW-1:0]));
  assign ext1    = ACC_DW'($signed(in_dat[2*MAC_DW-1:MAC_DW]));
  assign sum0    = lane_add(acc0, ext0);
  assign sum1    = lane_add(acc1, ext1);
  assign len_cfg = (cfg_acc_len == 8'd0) ? 9'd256 : {1'b0, cfg_acc_len};
  assign cnt_nxt = cnt + 9'd1;

  assign in_rdy  = (count != 2'd2);
  assign out_vld = (count != 2'd0);
  assign out_dat = mem[rd_ptr];
  assign busy    = (state == ACC);
  assign accept  = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  always_comb begin
    push     = 1'b0;
    push_dat = {sum1, sum0};
    if (accept) begin
      if (state == IDLE) begin
        push     = (len_cfg == 9'd1);
        push_dat = {ext1, ext0};
      end else begin
        push     = (cnt_nxt == len_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      acc0  <= '0;
      acc1  <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          // The first beat loads rather than adds, so stale sums never leak into a new group.
          if (len_cfg != 9'd1) begin
            acc0  <= ext0;
            acc1  <= ext1;
            cnt   <= 9'd1;
            len_q <= len_cfg;
            state <= ACC;
          end
        end
        ACC: begin
          if (cnt_nxt == len_q) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            acc0 <= sum0;
            acc1 <= sum1;
            cnt  <= cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_psum_accumulator.sv
// Directed bench for mac_psum_accumulator: default-width instance plus an ACC_DW=24 instance for overflow.
module tb_mac_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_acc_len;
  logic        in_vld;
  logic        in_vld24;
  logic [41:0] in_dat;
  logic        out_rdy;
  logic        in_rdy;
  logic        out_vld;
  logic [63:0] out_dat;
  logic        busy;
  logic        in_rdy24;
  logic        out_vld24;
  logic [47:0] out_dat24;
  logic        busy24;

  logic [63:0] exp_q[$];
  logic [47:0] exp24_q[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  mac_psum_accumulator dut (
    .clk(clk), .rst_n(rst_n), .cfg_acc_len(cfg_acc_len),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .busy(busy)
  );

  mac_psum_accumulator #(.MAC_DW(21), .ACC_DW(24)) dut24 (
    .clk(clk), .rst_n(rst_n), .cfg_acc_len(cfg_acc_len),
    .in_vld(in_vld24), .in_rdy(in_rdy24), .in_dat(in_dat),
    .out_vld(out_vld24), .out_rdy(out_rdy), .out_dat(out_dat24), .busy(busy24)
  );

  function automatic logic [63:0] pack32(input longint l0, input longint l1);
    return {32'(l1), 32'(l0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock: score any output leaving the DUTs, then drop vld on inputs that were taken.
  task automatic tick();
    logic a, b;
    @(negedge clk);
    if (out_vld && out_rdy) begin
      if (exp_q.size() == 0) chk("unexpected_out", out_dat, 64'hx);
      else chk("out_dat", out_dat, exp_q.pop_front());
    end
    if (out_vld24 && out_rdy) begin
      if (exp24_q.size() == 0) chk("unexpected_out24", {16'd0, out_dat24}, 64'hx);
      else chk("out_dat24", {16'd0, out_dat24}, {16'd0, exp24_q.pop_front()});
    end
    a = in_vld && in_rdy;
    b = in_vld24 && in_rdy24;
    @(posedge clk);
    #1;
    if (a) in_vld = 1'b0;
    if (b) in_vld24 = 1'b0;
  endtask

  task automatic send_beat(input int l0, input int l1);
    int n = 0;
    in_dat = {21'(l1), 21'(l0)};
    in_vld = 1'b1;
    while (in_vld && n < 100) begin
      tick();
      n++;
    end
    if (in_vld) begin
      chk("send_timeout", 64'd0, 64'd1);
      in_vld = 1'b0;
    end
  endtask

  task automatic send24(input int l0, input int l1);
    int n = 0;
    in_dat   = {21'(l1), 21'(l0)};
    in_vld24 = 1'b1;
    while (in_vld24 && n < 100) begin
      tick();
      n++;
    end
    if (in_vld24) begin
      chk("send24_timeout", 64'd0, 64'd1);
      in_vld24 = 1'b0;
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((exp_q.size() != 0 || exp24_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_pending", 64'(exp_q.size() + exp24_q.size()), 64'd0);
  endtask

  initial begin
    longint s0, s1;
    int     len, l0, l1;

    // Reset state
    rst_n = 1'b0; cfg_acc_len = 8'd4; in_vld = 1'b0; in_vld24 = 1'b0;
    in_dat = '0; out_rdy = 1'b1;
    #2;
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_dat", out_dat, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // len=4 basic group
    cfg_acc_len = 8'd4;
    send_beat(100, -1);
    chk("s29_busy_b1", 64'(busy), 64'd1);
    send_beat(-50, -1);
    send_beat(7, -1);
    chk("s29_vld_b3", 64'(out_vld), 64'd0);
    chk("s29_busy_b3", 64'(busy), 64'd1);
    exp_q.push_back(pack32(60, -4));
    send_beat(3, -1);
    chk("s29_vld_b4", 64'(out_vld), 64'd1);
    chk("s29_busy_b4", 64'(busy), 64'd0);
    tick();
    chk("s29_vld_pulse", 64'(out_vld), 64'd0);

    // len=1 extreme lane values
    cfg_acc_len = 8'd1;
    exp_q.push_back({32'h000F_FFFF, 32'hFFF0_0000});
    send_beat(-1048576, 1048575);
    chk("s30_busy", 64'(busy), 64'd0);
    chk("s30_vld", 64'(out_vld), 64'd1);
    wait_empty();

    // Back-pressure with len=1
    out_rdy = 1'b0;
    exp_q.push_back(pack32(11, -11));
    exp_q.push_back(pack32(22, -22));
    exp_q.push_back(pack32(33, -33));
    send_beat(11, -11);
    send_beat(22, -22);
    chk("s31_rdy_full", 64'(in_rdy), 64'd0);
    in_dat = {21'(-33), 21'(33)};
    in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s31_hold_dat", out_dat, exp_q[0]);
      chk("s31_hold_rdy", 64'(in_rdy), 64'd0);
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 20 && in_vld; i++) tick();
    chk("s31_third_taken", 64'(in_vld), 64'd0);
    wait_empty();

    // Reset mid-group discards partial sums
    cfg_acc_len = 8'd4;
    send_beat(1, 1);
    send_beat(2, 2);
    chk("s33_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("s33_rst_busy", 64'(busy), 64'd0);
    chk("s33_rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("s33_rst_vld", 64'(out_vld), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cfg_acc_len = 8'd2;
    exp_q.push_back(pack32(10, 0));
    send_beat(5, 0);
    send_beat(5, 0);
    wait_empty();
    repeat (3) tick();

    // Length latched at group start
    cfg_acc_len = 8'd3;
    send_beat(1, 0);
    cfg_acc_len = 8'd1;
    send_beat(2, 0);
    chk("s34_vld_b2", 64'(out_vld), 64'd0);
    chk("s34_busy_b2", 64'(busy), 64'd1);
    exp_q.push_back(pack32(6, 0));
    send_beat(3, 0);
    chk("s34_vld_b3", 64'(out_vld), 64'd1);
    wait_empty();
    exp_q.push_back(pack32(9, -9));
    send_beat(9, -9);
    chk("s34_len1_busy", 64'(busy), 64'd0);
    chk("s34_len1_vld", 64'(out_vld), 64'd1);
    wait_empty();

    // cfg_acc_len=0 means 256 beats
    cfg_acc_len = 8'd0;
    for (int i = 0; i < 255; i++) send_beat(1, -1);
    chk("len256_busy", 64'(busy), 64'd1);
    chk("len256_vld", 64'(out_vld), 64'd0);
    exp_q.push_back(pack32(256, -256));
    send_beat(1, -1);
    chk("len256_done_busy", 64'(busy), 64'd0);
    wait_empty();

    // Random groups with idle gaps
    for (int g = 0; g < 4; g++) begin
      len = $urandom_range(1, 6);
      cfg_acc_len = 8'(len);
      s0 = 0; s1 = 0;
      for (int b = 0; b < len; b++) begin
        l0 = int'($urandom_range(0, 2097151)) - 1048576;
        l1 = int'($urandom_range(0, 2097151)) - 1048576;
        s0 += l0; s1 += l1;
        if (b == len - 1) exp_q.push_back(pack32(s0, s1));
        repeat ($urandom_range(0, 2)) tick();
        send_beat(l0, l1);
      end
    end
    wait_empty();

    // ACC_DW=24 overflow: 16 x 1048575 and 16 x -1048576
    cfg_acc_len = 8'd16;
`ifdef ACC_SATURATE_EN
    exp24_q.push_back({24'h80_0000, 24'h7F_FFFF});
`else
    exp24_q.push_back({24'h00_0000, 24'hFF_FFF0});
`endif
    for (int i = 0; i < 16; i++) send24(1048575, -1048576);
    chk("s32_busy24", 64'(busy24), 64'd0);
    wait_empty();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
